// File: rtl/vec_stream_unit.sv
// vec_stream_unit: streams LANES-wide beats of two operand vectors through
// a saturating elementwise ALU (ADD/SUB/MUL/SCALE/DELTA/RELU) or reduces
// them to a single scalar (DOT/MAX) emitted as one result beat.
module vec_stream_unit #(
  parameter int WIDTH  = 128,
  parameter int LANES  = 8,
  parameter int DATA_W = 16,
  parameter int FRAC   = 8
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [2:0]                op,
  input  logic [DATA_W-1:0]         data_inK,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   in1,
  input  logic [LANES*DATA_W-1:0]   in2,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DATA_W-1:0]   out_data,
  output logic                      out_last,
  output logic                      busy,
  output logic                      done
);

  localparam int BEATS  = WIDTH / LANES;
  localparam int CNT_W  = $clog2(BEATS + 1);
  localparam int ACC_W  = DATA_W + $clog2(WIDTH) + 1;
  localparam int WIDE_W = 2 * DATA_W + $clog2(WIDTH) + 2;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_MUL   = 3'd2;
  localparam logic [2:0] OP_SCALE = 3'd3;
  localparam logic [2:0] OP_DELTA = 3'd4;
  localparam logic [2:0] OP_RELU  = 3'd5;
  localparam logic [2:0] OP_DOT   = 3'd6;
  localparam logic [2:0] OP_MAX   = 3'd7;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_RESULT = 2'd2} state_t;
  typedef logic signed [WIDE_W-1:0] wide_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  localparam wide_t ONE_W    = wide_t'(1'b1);
  localparam wide_t ZERO_W   = wide_t'(1'b0);
  localparam wide_t DATA_MAX = (ONE_W <<< (DATA_W - 1)) - ONE_W;
  localparam wide_t DATA_MIN = -(ONE_W <<< (DATA_W - 1));
  localparam wide_t ACC_MAX  = (ONE_W <<< (ACC_W - 1)) - ONE_W;
  localparam wide_t ACC_MIN  = -(ONE_W <<< (ACC_W - 1));

  // Sign-extend one element to the wide arithmetic width.
  function automatic wide_t sext_data(input logic [DATA_W-1:0] v);
    return {{(WIDE_W-DATA_W){v[DATA_W-1]}}, v};
  endfunction

  // Sign-extend the accumulator to the wide arithmetic width.
  function automatic wide_t sext_acc(input acc_t v);
    return {{(WIDE_W-ACC_W){v[ACC_W-1]}}, v};
  endfunction

  // Clamp a wide value into the element range.
  function automatic logic [DATA_W-1:0] sat_data(input wide_t v);
    if (v > DATA_MAX)      return DATA_MAX[DATA_W-1:0];
    else if (v < DATA_MIN) return DATA_MIN[DATA_W-1:0];
    else                   return v[DATA_W-1:0];
  endfunction

  // Clamp a wide value into the accumulator range.
  function automatic acc_t sat_acc(input wide_t v);
    if (v > ACC_MAX)      return ACC_MAX[ACC_W-1:0];
    else if (v < ACC_MIN) return ACC_MIN[ACC_W-1:0];
    else                  return v[ACC_W-1:0];
  endfunction

  // One lane of the elementwise ALU; products are rescaled by an arithmetic
  // shift so Q-format rounding is toward negative infinity.
  function automatic logic [DATA_W-1:0] lane_op(input logic [2:0] opc,
                                                input logic [DATA_W-1:0] a_raw,
                                                input logic [DATA_W-1:0] b_raw,
                                                input logic [DATA_W-1:0] k_raw);
    wide_t a = sext_data(a_raw);
    wide_t b = sext_data(b_raw);
    wide_t k = sext_data(k_raw);
    wide_t r;
    case (opc)
      OP_ADD:   r = a + b;
      OP_SUB:   r = a - b;
      OP_MUL:   r = (a * b) >>> FRAC;
      OP_SCALE: r = (a * k) >>> FRAC;
      OP_DELTA: r = a + k;
      OP_RELU:  r = (a < ZERO_W) ? ZERO_W : a;
      default:  r = ZERO_W;
    endcase
    return sat_data(r);
  endfunction

  state_t                    state_r, state_next_s;
  logic [2:0]                op_r;
  logic [DATA_W-1:0]         k_r;
  logic [CNT_W-1:0]          beat_cnt_r;
  acc_t                      acc_r, acc_next_s;
  logic                      out_valid_r, out_last_r, busy_r, done_r;
  logic [LANES*DATA_W-1:0]   out_data_r, elem_res_s, result_beat_s;
  wide_t                     beat_dot_s, acc_sum_s;
  acc_t                      beat_max_s, lane_acc_s;
  logic                      in_ready_s, is_red_s, inputs_left_s, last_in_s;
  logic                      accept_s, elem_accept_s, red_accept_s, out_hs_s;

  assign is_red_s      = (op_r == OP_DOT) || (op_r == OP_MAX);
  assign inputs_left_s = beat_cnt_r < CNT_W'(BEATS);
  assign last_in_s     = beat_cnt_r == CNT_W'(BEATS - 1);
  assign accept_s      = in_valid && in_ready_s;
  assign elem_accept_s = accept_s && !is_red_s;
  assign red_accept_s  = accept_s && is_red_s;
  assign out_hs_s      = out_valid_r && out_ready;

  // Per-beat datapath: elementwise lane results plus the beat's dot and max terms.
  always_comb begin
    elem_res_s = {(LANES*DATA_W){1'b0}};
    beat_dot_s = ZERO_W;
    beat_max_s = {{(ACC_W-DATA_W){in1[DATA_W-1]}}, in1[DATA_W-1:0]};
    lane_acc_s = beat_max_s;
    for (int j = 0; j < LANES; j++) begin
      elem_res_s[j*DATA_W +: DATA_W] = lane_op(op_r, in1[j*DATA_W +: DATA_W],
                                               in2[j*DATA_W +: DATA_W], k_r);
      beat_dot_s = beat_dot_s + ((sext_data(in1[j*DATA_W +: DATA_W]) *
                                  sext_data(in2[j*DATA_W +: DATA_W])) >>> FRAC);
      lane_acc_s = {{(ACC_W-DATA_W){in1[j*DATA_W+DATA_W-1]}}, in1[j*DATA_W +: DATA_W]};
      if (lane_acc_s > beat_max_s) beat_max_s = lane_acc_s;
      else                         beat_max_s = beat_max_s;
    end
  end

  // Accumulator update; MAX seeds from the first beat so all-negative vectors work.
  always_comb begin
    acc_next_s    = acc_r;
    acc_sum_s     = sext_acc(acc_r) + beat_dot_s;
    result_beat_s = {(LANES*DATA_W){1'b0}};
    if (red_accept_s) begin
      if (op_r == OP_DOT) acc_next_s = sat_acc(acc_sum_s);
      else if ((beat_cnt_r == {CNT_W{1'b0}}) || (beat_max_s > acc_r)) acc_next_s = beat_max_s;
      else acc_next_s = acc_r;
    end else begin
      acc_next_s = acc_r;
    end
    result_beat_s[DATA_W-1:0] = sat_data(sext_acc(acc_next_s));
  end

  // Next-state logic and input-side flow control.
  always_comb begin
    state_next_s = state_r;
    in_ready_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) state_next_s = ST_RUN;
        else       state_next_s = ST_IDLE;
      end
      ST_RUN: begin
        if (is_red_s) begin
          in_ready_s = inputs_left_s;
          if (in_valid && inputs_left_s && last_in_s) state_next_s = ST_RESULT;
          else                                        state_next_s = ST_RUN;
        end else begin
          in_ready_s = inputs_left_s && (!out_valid_r || out_ready);
          if (out_hs_s && out_last_r) state_next_s = ST_IDLE;
          else                        state_next_s = ST_RUN;
        end
      end
      ST_RESULT: begin
        if (out_hs_s) state_next_s = ST_IDLE;
        else          state_next_s = ST_RESULT;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_r <= ST_IDLE;
    else          state_r <= state_next_s;
  end

  // Operation context: opcode/scalar latched at start, beat counter and accumulator.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_r       <= 3'd0;
      k_r        <= {DATA_W{1'b0}};
      beat_cnt_r <= {CNT_W{1'b0}};
      acc_r      <= {ACC_W{1'b0}};
    end else if ((state_r == ST_IDLE) && start) begin
      op_r       <= op;
      k_r        <= data_inK;
      beat_cnt_r <= {CNT_W{1'b0}};
      acc_r      <= {ACC_W{1'b0}};
    end else begin
      beat_cnt_r <= accept_s ? beat_cnt_r + CNT_W'(1) : beat_cnt_r;
      acc_r      <= acc_next_s;
    end
  end

  // Output register: loads on an accepted beat or the final reduction, holds under backpressure.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_data_r  <= {(LANES*DATA_W){1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      busy_r <= state_next_s != ST_IDLE;
      done_r <= out_hs_s && out_last_r;
      if (elem_accept_s) begin
        out_valid_r <= 1'b1;
        out_last_r  <= last_in_s;
        out_data_r  <= elem_res_s;
      end else if (red_accept_s && last_in_s) begin
        out_valid_r <= 1'b1;
        out_last_r  <= 1'b1;
        out_data_r  <= result_beat_s;
      end else if (out_hs_s) begin
        out_valid_r <= 1'b0;
        out_last_r  <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
        out_last_r  <= out_last_r;
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign out_data  = out_data_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_vec_stream_unit.sv
// Randomized self-checking bench for vec_stream_unit (WIDTH=8, LANES=4, Q8.8).
module tb_vec_stream_unit;
  localparam int NEL = 8;
  localparam int LN  = 4;
  localparam int BT  = NEL / LN;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [15:0] data_inK = 16'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in1 = 64'd0;
  logic [63:0] in2 = 64'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic        out_last, busy, done;

  int n_checks = 0;
  int n_errors = 0;
  int v1[NEL];
  int v2[NEL];

  always #5 clock = ~clock;

  vec_stream_unit #(.WIDTH(8), .LANES(4), .DATA_W(16), .FRAC(8)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .op(op), .data_inK(data_inK),
    .in_valid(in_valid), .in_ready(in_ready), .in1(in1), .in2(in2),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  // Reference arithmetic straight from the operation definitions.
  function automatic int ref_elem(input int opc, input int a, input int b, input int k);
    case (opc)
      0: return sat16(longint'(a) + b);
      1: return sat16(longint'(a) - b);
      2: return sat16((longint'(a) * b) >>> 8);
      3: return sat16((longint'(a) * k) >>> 8);
      4: return sat16(longint'(a) + k);
      5: return (a < 0) ? 0 : a;
      default: return 0;
    endcase
  endfunction

  function automatic int rnd16();
    logic signed [15:0] t;
    t = 16'($urandom);
    return int'(t);
  endfunction

  function automatic logic [63:0] pack_beat(input int second, input int beat);
    logic [63:0] b;
    b = 64'd0;
    for (int j = 0; j < LN; j++)
      b[j*16 +: 16] = 16'((second != 0) ? v2[beat*LN+j] : v1[beat*LN+j]);
    return b;
  endfunction

  task automatic fill(input int a, input int b);
    for (int i = 0; i < NEL; i++) begin
      v1[i] = a;
      v2[i] = b;
    end
  endtask

  // mode 0: no stalls, 1: random valid/ready, 2: out_ready held low 6 cycles
  task automatic run_op(input int opc, input int k, input int mode);
    logic [63:0] exp_q[$];
    logic [63:0] e, prev_data;
    longint s;
    int m, c, n_acc, n_out, nexp;
    bit red, last_hs, lat_exp, prev_hold, in_hs, out_hs, exp_rdy;
    red = (opc >= 6);
    if (!red) begin
      for (int i = 0; i < BT; i++) begin
        e = 64'd0;
        for (int j = 0; j < LN; j++)
          e[j*16 +: 16] = 16'(ref_elem(opc, v1[i*LN+j], v2[i*LN+j], k));
        exp_q.push_back(e);
      end
    end else begin
      s = 0;
      m = v1[0];
      for (int i = 0; i < NEL; i++) begin
        s += (longint'(v1[i]) * v2[i]) >>> 8;
        if (v1[i] > m) m = v1[i];
      end
      e = 64'd0;
      e[15:0] = 16'((opc == 6) ? sat16(s) : m);
      exp_q.push_back(e);
    end
    nexp = exp_q.size();

    @(negedge clock);
    start = 1'b1; op = 3'(opc); data_inK = 16'(k); in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clock);
    start = 1'b0; op = 3'($urandom); data_inK = 16'($urandom);
    #1 check("busy_start", 64'(busy), 64'd1);
    c = 0; n_acc = 0; n_out = 0; last_hs = 0; lat_exp = 0; prev_hold = 0; prev_data = 64'd0;
    forever begin
      if (last_hs) begin
        start = 1'b0; in_valid = 1'b0; out_ready = 1'($urandom);
      end else begin
        start = ($urandom_range(0, 3) == 0);
        op = 3'($urandom); data_inK = 16'($urandom);
        in_valid = (mode == 1) ? 1'($urandom) : 1'b1;
        in1 = (n_acc < BT) ? pack_beat(0, n_acc) : {$urandom, $urandom};
        in2 = (n_acc < BT) ? pack_beat(1, n_acc) : {$urandom, $urandom};
        out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ($urandom_range(0, 2) != 0) : (c >= 6);
      end
      #1;
      check("done", 64'(done), 64'(last_hs));
      if (last_hs) begin
        check("busy_end", 64'(busy), 64'd0);
        break;
      end
      if (lat_exp) check("latency", 64'(out_valid), 64'd1);
      if (prev_hold) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_data", out_data, prev_data);
      end
      exp_rdy = (n_acc < BT) && (red || !out_valid || out_ready);
      check("in_ready", 64'(in_ready), 64'(exp_rdy));
      in_hs = in_valid && in_ready;
      out_hs = out_valid && out_ready;
      if (out_hs) begin
        if (n_out < nexp) begin
          check("out_data", out_data, exp_q[n_out]);
          check("out_last", 64'(out_last), 64'(n_out == nexp - 1));
        end else begin
          check("extra_beat", 64'd1, 64'd0);
        end
        n_out++;
        last_hs = (n_out == nexp);
      end
      if (in_hs) n_acc++;
      lat_exp = in_hs && (!red || n_acc == BT);
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      @(negedge clock);
      c++;
      if (c > 300) begin
        check("timeout", 64'd1, 64'd0);
        break;
      end
    end
  endtask

  task automatic reset_mid_op();
    fill(256, 512);
    @(negedge clock);
    start = 1'b1; op = 3'd0; data_inK = 16'd0; out_ready = 1'b0;
    @(negedge clock);
    start = 1'b0; in_valid = 1'b1; in1 = pack_beat(0, 0); in2 = pack_beat(1, 0);
    @(negedge clock);
    in_valid = 1'b0;
    #1 check("rst_pre_valid", 64'(out_valid), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    #1 check("rst_no_done", 64'(done), 64'd0);
    check("rst_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    int opc;
    repeat (2) @(negedge clock);
    check("init_out_valid", 64'(out_valid), 64'd0);
    check("init_out_last", 64'(out_last), 64'd0);
    check("init_in_ready", 64'(in_ready), 64'd0);
    check("init_busy", 64'(busy), 64'd0);
    check("init_done", 64'(done), 64'd0);
    check("init_out_data", out_data, 64'd0);
    reset_n = 1'b1;

    fill(16'sh0100, 16'sh0200);     run_op(0, 0, 0);
    fill(16'sh7F00, 16'sh0200);     run_op(0, 0, 0);
    fill(-32512, 16'sh0200);        run_op(1, 0, 0);
    fill(16'sh0200, 16'sh0200);     run_op(6, 0, 0);
    for (int i = 0; i < NEL; i++) begin
      v1[i] = rnd16();
      v2[i] = rnd16();
    end
    run_op(2, 0, 2);
    for (int i = 0; i < NEL; i++) v1[i] = (i % 2 != 0) ? 128 : -256;
    run_op(5, 0, 0);
    v1 = '{512, -768, 1024, 0, -256, 256, -512, 768};
    run_op(7, 0, 1);
    for (int i = 0; i < NEL; i++) v1[i] = -1000 - 37 * i;
    run_op(7, 0, 0);
    fill(16'sh0180, -640);          run_op(3, -384, 1);

    reset_mid_op();
    fill(16'sh0100, 16'sh0200);     run_op(0, 0, 0);

    for (int t = 0; t < 30; t++) begin
      opc = $urandom_range(0, 7);
      for (int i = 0; i < NEL; i++) begin
        if (opc == 6) begin
          v1[i] = $urandom_range(0, 2047) - 1024;
          v2[i] = $urandom_range(0, 2047) - 1024;
        end else begin
          v1[i] = rnd16();
          v2[i] = rnd16();
        end
      end
      run_op(opc, rnd16(), $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
